// File: rtl/wb_single_initiator.sv
// Wishbone classic (B3) single-beat initiator.
// Accepts one read/write command over valid/ready and runs it as one bus cycle.
// The cycle ends on ack, err or a bounded timeout, and the result comes back
// as one valid/ready response. Only one transaction is in flight at a time.
// Every output is a register, so no input reaches an output combinationally.
module wb_single_initiator #(
   parameter int ADR_W   = 30,
   parameter int DAT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   // command channel
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_we,
   input  logic [ADR_W-1:0]   cmd_adr,
   input  logic [DAT_W-1:0]   cmd_dat,
   input  logic [DAT_W/8-1:0] cmd_sel,
   // response channel
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DAT_W-1:0]   rsp_dat,
   output logic               rsp_err,
   output logic               rsp_timeout,
   // Wishbone initiator port
   output logic               wb_cyc,
   output logic               wb_stb,
   output logic               wb_we,
   output logic [ADR_W-1:0]   wb_adr,
   output logic [DAT_W-1:0]   wb_dat_w,
   output logic [DAT_W/8-1:0] wb_sel,
   input  logic [DAT_W-1:0]   wb_dat_r,
   input  logic               wb_ack,
   input  logic               wb_err
);

   localparam int SEL_W = DAT_W / 8;
   localparam int CNT_W = 16;
   // Count value of the last cycle stb may stay up without a reply.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic               cmd_ready_q;
   logic               rsp_valid_q;
   logic [DAT_W-1:0]   rsp_dat_q;
   logic               rsp_err_q;
   logic               rsp_timeout_q;
   logic               wb_cyc_q;
   logic               wb_stb_q;
   logic               wb_we_q;
   logic [ADR_W-1:0]   wb_adr_q;
   logic [DAT_W-1:0]   wb_dat_w_q;
   logic [SEL_W-1:0]   wb_sel_q;

   // Saturating next value of the bus-cycle counter.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Control FSM: command accept, bus cycle with termination, response hold.
   always_ff @(posedge sys_clk) begin
      // NOTE: non-blocking assignments only here; every right-hand side then
      // reads the pre-edge value regardless of statement order.
      if (sys_rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_dat_q     <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         wb_cyc_q      <= 1'b0;
         wb_stb_q      <= 1'b0;
         wb_we_q       <= 1'b0;
         wb_adr_q      <= '0;
         wb_dat_w_q    <= '0;
         wb_sel_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  wb_we_q     <= cmd_we;
                  wb_adr_q    <= cmd_adr;
                  wb_dat_w_q  <= cmd_dat;
                  wb_sel_q    <= cmd_sel;
                  wb_cyc_q    <= 1'b1;
                  wb_stb_q    <= 1'b1;
                  cnt_q       <= '0;
                  cmd_ready_q <= 1'b0;
                  state_q     <= S_BUS;
               end
            end

            S_BUS: begin
               cnt_q <= cnt_d;
               // err wins over ack; a reply on the last counted cycle is a
               // real reply, not a timeout.
               if (wb_err) begin
                  rsp_dat_q     <= '0;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  wb_cyc_q      <= 1'b0;
                  wb_stb_q      <= 1'b0;
                  state_q       <= S_RESP;
               end else if (wb_ack) begin
                  rsp_dat_q     <= wb_we_q ? '0 : wb_dat_r;
                  rsp_err_q     <= 1'b0;
                  rsp_timeout_q <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  wb_cyc_q      <= 1'b0;
                  wb_stb_q      <= 1'b0;
                  state_q       <= S_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  rsp_dat_q     <= '0;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  rsp_valid_q   <= 1'b1;
                  wb_cyc_q      <= 1'b0;
                  wb_stb_q      <= 1'b0;
                  state_q       <= S_RESP;
               end
            end

            S_RESP: begin
               // rsp_dat deliberately keeps its value after acceptance.
               if (rsp_ready) begin
                  rsp_valid_q   <= 1'b0;
                  rsp_err_q     <= 1'b0;
                  rsp_timeout_q <= 1'b0;
                  cmd_ready_q   <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end

            // NOTE: the unused encoding recovers to IDLE instead of locking up.
            default: begin
               state_q     <= S_IDLE;
               cmd_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               wb_cyc_q    <= 1'b0;
               wb_stb_q    <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_dat     = rsp_dat_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign wb_cyc      = wb_cyc_q;
   assign wb_stb      = wb_stb_q;
   assign wb_we       = wb_we_q;
   assign wb_adr      = wb_adr_q;
   assign wb_dat_w    = wb_dat_w_q;
   assign wb_sel      = wb_sel_q;

endmodule

// File: tb/tb_wb_single_initiator.sv
// Directed bench for wb_single_initiator (TIMEOUT=8).
// Inputs change on the falling edge. Outputs are sampled on the falling edge.
module tb_wb_single_initiator;

   localparam int ADR_W   = 30;
   localparam int DAT_W   = 32;
   localparam int SEL_W   = 4;
   localparam int TIMEOUT = 8;

   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_we = 1'b0;
   logic [ADR_W-1:0] cmd_adr = '0;
   logic [DAT_W-1:0] cmd_dat = '0;
   logic [SEL_W-1:0] cmd_sel = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [DAT_W-1:0] rsp_dat;
   logic             rsp_err;
   logic             rsp_timeout;
   logic             wb_cyc;
   logic             wb_stb;
   logic             wb_we;
   logic [ADR_W-1:0] wb_adr;
   logic [DAT_W-1:0] wb_dat_w;
   logic [SEL_W-1:0] wb_sel;
   logic [DAT_W-1:0] wb_dat_r = '0;
   logic             wb_ack = 1'b0;
   logic             wb_err = 1'b0;

   int total  = 0;
   int passed = 0;

   wb_single_initiator #(
      .ADR_W   (ADR_W),
      .DAT_W   (DAT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_we      (cmd_we),
      .cmd_adr     (cmd_adr),
      .cmd_dat     (cmd_dat),
      .cmd_sel     (cmd_sel),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_dat     (rsp_dat),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .wb_cyc      (wb_cyc),
      .wb_stb      (wb_stb),
      .wb_we       (wb_we),
      .wb_adr      (wb_adr),
      .wb_dat_w    (wb_dat_w),
      .wb_sel      (wb_sel),
      .wb_dat_r    (wb_dat_r),
      .wb_ack      (wb_ack),
      .wb_err      (wb_err)
   );

   always #5 sys_clk = ~sys_clk;

   // Hard time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required done", $time);
      $fatal(1, "watchdog expired");
   end

   // Present a command at a falling edge. It is accepted at the next rising edge.
   // The task returns at the falling edge of the first BUS cycle.
   task automatic send_cmd(input logic we, input logic [ADR_W-1:0] adr,
                           input logic [DAT_W-1:0] dat, input logic [SEL_W-1:0] sel);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      @(posedge sys_clk);
      @(negedge sys_clk);
      cmd_valid = 1'b0;
   endtask

   // Act as the responder from the first BUS cycle (index 0) onward.
   // It replies in cycle ack_at (a negative value means it never replies).
   // It counts cycles with stb high, and counts strobed cycles whose request
   // fields differ from the expected values. It stops at the falling edge
   // where rsp_valid is first seen.
   task automatic run_bus(input int ack_at, input logic use_err, input logic [DAT_W-1:0] rdata,
                          input logic exp_we, input logic [ADR_W-1:0] exp_adr,
                          input logic [DAT_W-1:0] exp_dat, input logic [SEL_W-1:0] exp_sel,
                          output int stb_cycles, output int fld_bad, output logic done);
      stb_cycles = 0;
      fld_bad    = 0;
      done       = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (rsp_valid === 1'b1) begin
            done = 1'b1;
            break;
         end
         if (wb_stb === 1'b1) begin
            stb_cycles++;
            if (wb_cyc !== 1'b1 || wb_we !== exp_we || wb_adr !== exp_adr ||
                wb_dat_w !== exp_dat || wb_sel !== exp_sel) fld_bad++;
         end
         wb_ack   = (i == ack_at);
         wb_err   = use_err && (i == ack_at);
         wb_dat_r = (i == ack_at) ? rdata : '0;
         @(negedge sys_clk);
      end
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      wb_dat_r = '0;
   endtask

   // Accept a pending response with a one-cycle rsp_ready pulse.
   task automatic accept_rsp();
      rsp_ready = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      repeat (5) @(posedge sys_clk);
      @(negedge sys_clk);
      total++;
      if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, wb_cyc, wb_stb, wb_we} !== 7'b1000000 ||
          rsp_dat !== '0 || wb_adr !== '0 || wb_dat_w !== '0 || wb_sel !== '0)
         $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b err=%b to=%b cyc=%b stb=%b we=%b dat=%h, required cmd_ready=1 all else 0",
                  cmd_ready, rsp_valid, rsp_err, rsp_timeout, wb_cyc, wb_stb, wb_we, rsp_dat);
      else passed++;
      sys_rst = 1'b0;
      @(negedge sys_clk);
      total++;
      if (cmd_ready !== 1'b1 || wb_cyc !== 1'b0)
         $display("FAIL reset_release: cmd_ready=%b cyc=%b, required 1/0", cmd_ready, wb_cyc);
      else passed++;
   endtask

   task automatic test_read();
      int sc, fb;
      logic dn;
      send_cmd(1'b0, 30'h40, 32'h0, 4'hF);
      total++;
      if (cmd_ready !== 1'b0 || wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_we !== 1'b0 || wb_adr !== 30'h40)
         $display("FAIL read_start: cmd_ready=%b cyc=%b stb=%b we=%b adr=%h, required 0/1/1/0/40",
                  cmd_ready, wb_cyc, wb_stb, wb_we, wb_adr);
      else passed++;
      run_bus(1, 1'b0, 32'hDEADBEEF, 1'b0, 30'h40, 32'h0, 4'hF, sc, fb, dn);
      total++;
      if (!dn || sc != 2 || fb != 0)
         $display("FAIL read_bus: done=%b stb_cycles=%0d field_errs=%0d, required 1/2/0", dn, sc, fb);
      else passed++;
      total++;
      if (rsp_dat !== 32'hDEADBEEF || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 ||
          wb_cyc !== 1'b0 || wb_stb !== 1'b0 || cmd_ready !== 1'b0)
         $display("FAIL read_rsp: dat=%h err=%b to=%b cyc=%b stb=%b cmd_ready=%b, required deadbeef/0/0/0/0/0",
                  rsp_dat, rsp_err, rsp_timeout, wb_cyc, wb_stb, cmd_ready);
      else passed++;
      accept_rsp();
      total++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL read_accept: rsp_valid=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
      else passed++;
   endtask

   task automatic test_write();
      int sc, fb;
      logic dn;
      send_cmd(1'b1, 30'h10, 32'h12345678, 4'hF);
      // Responder drives nonzero read data; a write must still return 0.
      run_bus(2, 1'b0, 32'hFFFFFFFF, 1'b1, 30'h10, 32'h12345678, 4'hF, sc, fb, dn);
      total++;
      if (!dn || sc != 3 || fb != 0)
         $display("FAIL write_bus: done=%b stb_cycles=%0d field_errs=%0d, required 1/3/0", dn, sc, fb);
      else passed++;
      total++;
      if (rsp_dat !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
         $display("FAIL write_rsp: dat=%h err=%b to=%b, required 0/0/0", rsp_dat, rsp_err, rsp_timeout);
      else passed++;
      total++;
      if (wb_cyc !== 1'b0 || wb_we !== 1'b1 || wb_adr !== 30'h10 || wb_dat_w !== 32'h12345678 || wb_sel !== 4'hF)
         $display("FAIL write_retain: cyc=%b we=%b adr=%h dat_w=%h sel=%h, required 0/1/10/12345678/f",
                  wb_cyc, wb_we, wb_adr, wb_dat_w, wb_sel);
      else passed++;
      accept_rsp();
   endtask

   task automatic test_bus_error();
      int sc, fb;
      logic dn;
      send_cmd(1'b0, 30'h3FF, 32'h0, 4'h3);
      run_bus(0, 1'b1, 32'hCAFEF00D, 1'b0, 30'h3FF, 32'h0, 4'h3, sc, fb, dn);
      total++;
      if (!dn || sc != 1 || fb != 0)
         $display("FAIL err_bus: done=%b stb_cycles=%0d field_errs=%0d, required 1/1/0", dn, sc, fb);
      else passed++;
      total++;
      if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_dat !== 32'h0)
         $display("FAIL err_rsp: err=%b to=%b dat=%h, required 1/0/0", rsp_err, rsp_timeout, rsp_dat);
      else passed++;
      accept_rsp();
      total++;
      if (rsp_err !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL err_accept: err=%b cmd_ready=%b, required 0/1", rsp_err, cmd_ready);
      else passed++;
   endtask

   task automatic test_timeout();
      int sc, fb;
      logic dn;
      send_cmd(1'b1, 30'h20, 32'h55AA55AA, 4'h1);
      run_bus(-1, 1'b0, 32'h0, 1'b1, 30'h20, 32'h55AA55AA, 4'h1, sc, fb, dn);
      total++;
      if (!dn || sc != TIMEOUT || fb != 0)
         $display("FAIL timeout_bus: done=%b stb_cycles=%0d field_errs=%0d, required 1/%0d/0", dn, sc, fb, TIMEOUT);
      else passed++;
      total++;
      if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_dat !== 32'h0 || wb_cyc !== 1'b0)
         $display("FAIL timeout_rsp: err=%b to=%b dat=%h cyc=%b, required 1/1/0/0", rsp_err, rsp_timeout, rsp_dat, wb_cyc);
      else passed++;
      accept_rsp();
      total++;
      if (rsp_timeout !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL timeout_accept: to=%b rsp_valid=%b cmd_ready=%b, required 0/0/1", rsp_timeout, rsp_valid, cmd_ready);
      else passed++;
   endtask

   // Ack on the last counted cycle (index TIMEOUT-1) is a normal ack.
   task automatic test_ack_at_limit();
      int sc, fb;
      logic dn;
      send_cmd(1'b0, 30'h44, 32'h0, 4'hF);
      run_bus(TIMEOUT - 1, 1'b0, 32'h13579BDF, 1'b0, 30'h44, 32'h0, 4'hF, sc, fb, dn);
      total++;
      if (!dn || sc != TIMEOUT || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_dat !== 32'h13579BDF)
         $display("FAIL ack_at_limit: done=%b stb_cycles=%0d err=%b to=%b dat=%h, required 1/%0d/0/0/13579bdf",
                  dn, sc, rsp_err, rsp_timeout, rsp_dat, TIMEOUT);
      else passed++;
      accept_rsp();
   endtask

   task automatic test_backpressure();
      int sc, fb, bad;
      logic dn;
      send_cmd(1'b0, 30'h88, 32'h0, 4'hF);
      run_bus(1, 1'b0, 32'hA5A55A5A, 1'b0, 30'h88, 32'h0, 4'hF, sc, fb, dn);
      total++;
      if (!dn || sc != 2)
         $display("FAIL bp_bus: done=%b stb_cycles=%0d, required 1/2", dn, sc);
      else passed++;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid !== 1'b1 || rsp_dat !== 32'hA5A55A5A || rsp_err !== 1'b0 ||
             rsp_timeout !== 1'b0 || cmd_ready !== 1'b0 || wb_cyc !== 1'b0 || wb_stb !== 1'b0) bad++;
         wb_ack   = (i % 3 == 0);
         wb_err   = (i == 5);
         wb_dat_r = 32'h11111111;
         @(negedge sys_clk);
      end
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      wb_dat_r = '0;
      total++;
      if (bad != 0 || rsp_valid !== 1'b1 || rsp_dat !== 32'hA5A55A5A || rsp_err !== 1'b0)
         $display("FAIL bp_hold: bad_cycles=%0d rsp_valid=%b dat=%h err=%b, required 0/1/a5a55a5a/0",
                  bad, rsp_valid, rsp_dat, rsp_err);
      else passed++;
      accept_rsp();
      total++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_dat !== 32'hA5A55A5A)
         $display("FAIL bp_accept: rsp_valid=%b cmd_ready=%b dat=%h, required 0/1/a5a55a5a",
                  rsp_valid, cmd_ready, rsp_dat);
      else passed++;
   endtask

   task automatic test_idle_stray();
      int bad;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         wb_ack = 1'b1;
         wb_err = (i == 2);
         @(negedge sys_clk);
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_cyc !== 1'b0) bad++;
      end
      wb_ack = 1'b0;
      wb_err = 1'b0;
      total++;
      if (bad != 0)
         $display("FAIL idle_stray: bad_cycles=%0d, required 0", bad);
      else passed++;
   endtask

   task automatic test_reset_mid_bus();
      int sc, fb;
      logic dn;
      send_cmd(1'b0, 30'h80, 32'h0, 4'hF);
      @(negedge sys_clk);
      // Second BUS cycle: reset arrives together with an ack and must win.
      sys_rst  = 1'b1;
      wb_ack   = 1'b1;
      wb_dat_r = 32'h77777777;
      @(negedge sys_clk);
      total++;
      if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL rst_mid_bus: cyc=%b stb=%b rsp_valid=%b cmd_ready=%b, required 0/0/0/1",
                  wb_cyc, wb_stb, rsp_valid, cmd_ready);
      else passed++;
      sys_rst  = 1'b0;
      wb_ack   = 1'b0;
      wb_dat_r = '0;
      @(negedge sys_clk);
      total++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL rst_release: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid);
      else passed++;
      send_cmd(1'b0, 30'h84, 32'h0, 4'hF);
      run_bus(1, 1'b0, 32'h0BADF00D, 1'b0, 30'h84, 32'h0, 4'hF, sc, fb, dn);
      total++;
      if (!dn || sc != 2 || fb != 0 || rsp_dat !== 32'h0BADF00D || rsp_err !== 1'b0)
         $display("FAIL rst_after_read: done=%b stb_cycles=%0d field_errs=%0d dat=%h err=%b, required 1/2/0/0badf00d/0",
                  dn, sc, fb, rsp_dat, rsp_err);
      else passed++;
      accept_rsp();
   endtask

   // Back-to-back with rsp_ready held high: 3 cycles between acceptances.
   task automatic test_back_to_back();
      int gap;
      logic seen;
      rsp_ready = 1'b1;
      send_cmd(1'b0, 30'h90, 32'h0, 4'hF);
      wb_ack   = 1'b1;
      wb_dat_r = 32'h24682468;
      @(negedge sys_clk);
      wb_ack   = 1'b0;
      wb_dat_r = '0;
      gap  = 1;
      seen = 1'b0;
      cmd_valid = 1'b1;
      cmd_adr   = 30'h94;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge sys_clk);
         gap++;
      end
      // The acceptance edge follows this cycle, so the spacing is gap + 1.
      @(posedge sys_clk);
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      total++;
      if (!seen || gap + 1 != 3 || wb_stb !== 1'b1 || wb_adr !== 30'h94)
         $display("FAIL back_to_back: seen=%b spacing=%0d stb=%b adr=%h, required 1/3/1/94",
                  seen, gap + 1, wb_stb, wb_adr);
      else passed++;
      wb_ack = 1'b1;
      @(negedge sys_clk);
      wb_ack = 1'b0;
      @(negedge sys_clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_bus_error();
      test_timeout();
      test_ack_at_limit();
      test_backpressure();
      test_idle_stray();
      test_reset_mid_bus();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
